mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-outstanding memory/IO port between the instruction fetch unit (IFU) and load-store unit (LSU).
//  Captures each requester's one-cycle request pulse and grants round-robin.
//  Issues one registered request downstream and routes the response to the granted requester only.
//  Sits between ifu/lsu and the SoC memory bus.
// PARAMETERS
//  ADDR_W          32   address width, all ports
//  DATA_W          32   data width, all ports
//  TIMEOUT_CYCLES  255  WAIT cycles before error response (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clock          in   1        single clock, all logic on posedge
//  reset          in   1        synchronous, active-low (reset==0 resets on posedge clock)
//  ifu_reqValid   in   1        one-cycle request pulse from IFU (read only)
//  ifu_addr       in   ADDR_W   fetch address, valid with ifu_reqValid
//  ifu_respValid  out  1        one-cycle response pulse to IFU
//  ifu_rdata      out  DATA_W   fetched word, valid with ifu_respValid, else 0
//  ifu_respErr    out  1        error flag, valid with ifu_respValid
//  lsu_reqValid   in   1        one-cycle request pulse from LSU
//  lsu_addr       in   ADDR_W   load/store address
//  lsu_wen        in   1        1=store, 0=load
//  lsu_wdata      in   DATA_W   store data
//  lsu_wmask      in   DATA_W/8 byte strobes
//  lsu_respValid  out  1        one-cycle response pulse to LSU
//  lsu_rdata      out  DATA_W   load data, valid with lsu_respValid, else 0
//  lsu_respErr    out  1        error flag, valid with lsu_respValid
//  mem_reqValid   out  1        registered one-cycle request to memory
//  mem_addr       out  ADDR_W   registered, held from REQ until next grant
//  mem_wen        out  1        registered
//  mem_wdata      out  DATA_W   registered
//  mem_wmask      out  DATA_W/8 registered
//  mem_respValid  in   1        one-cycle response pulse from memory
//  mem_rdata      in   DATA_W   read data, valid with mem_respValid
// BEHAVIOUR
//  Reset: state=IDLE; both slots empty; last_grant=IFU, so LSU wins the first tie.
//   mem_* outputs 0; resp* outputs 0; timeout counter 0.
//  Slots: one per requester.
//   - reqValid captures addr/wen/wdata/wmask and sets pending.
//   - pending clears in the cycle that requester's response is returned.
//   - A new pulse in that same cycle is captured (new pending=1).
//   - A pulse while pending=1 and no response that cycle is a protocol violation: ignored, flagged by assertion.
//  FSM: IDLE -> REQ -> WAIT -> IDLE.
//   - IDLE: if any slot pending, grant and load mem_* regs -> REQ.
//   - IDLE grant: one pending -> it wins; both pending -> the one != last_grant wins.
//   - IDLE grant updates last_grant. Nothing pending -> stay IDLE.
//   - REQ: mem_reqValid=1 for exactly this cycle -> WAIT.
//   - WAIT: on mem_respValid, drive owner's respValid=1 and rdata=mem_rdata combinationally in the same cycle.
//     Clear the owner slot; -> IDLE.
//   - Non-owner resp outputs stay 0.
//  mem_respValid outside WAIT is discarded (no output, no state change).
//  Latency: pulse at cycle 0 -> pending at 1 -> REQ (mem_reqValid) at 2 -> earliest response at 3.
//  Back-to-back: other requester's REQ follows 2 cycles after a response.
//  Reset low mid-transaction: FSM and slots cleared next edge; in-flight response afterwards discarded.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - 8-bit-or-wider counter runs in WAIT, clears on entry.
//   - Reaching TIMEOUT_CYCLES with no mem_respValid: owner gets respValid=1, respErr=1, rdata=0.
//   - Owner slot clears; -> IDLE. A late memory response is discarded as above.
//  MEM_ARB_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; respErr tied 0.
// STRUCTURE
//  mem_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_arb_state_t;
//   - typedef enum logic {OWN_IFU, OWN_LSU} mem_arb_owner_t;
//   - request-slot struct typedef.
//  Sub-module mem_arb_slot: one-entry capture buffer with pending flag, instantiated twice (IFU, LSU).
//  IFU instance ties wen=0, wmask=0.
// TESTING
//  1. IFU pulse addr=0x8000_0000; memory responds 1 cycle after REQ with 0x0000_0013.
//     -> mem_reqValid at cycle 2; ifu_respValid=1, ifu_rdata=0x13 at cycle 3; lsu_respValid stays 0.
//  2. IFU and LSU pulse the same cycle after reset; LSU store addr=0x1000, wdata=0xDEAD_BEEF, wmask=0xF.
//     -> LSU granted first with mem_wen=1; IFU issued 2 cycles after the LSU response.
//  3. Both pulse repeatedly for 8 transactions.
//     -> grants strictly alternate LSU, IFU, LSU, ...; no response routed to the wrong port.
//  4. mem_respValid with mem_rdata=0x55 asserted in IDLE.
//     -> no respValid on either port; FSM stays IDLE.
//  5. reset=0 for one cycle while in WAIT, then old response arrives.
//     -> all outputs 0, FSM IDLE, response discarded.
//  6. MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory silent.
//     -> 4 WAIT cycles, then ifu_respValid=1, ifu_respErr=1, ifu_rdata=0; late response ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner and request-slot types for the IFU/LSU memory arbiter
package mem_arb_pkg;
    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_arb_state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} mem_arb_owner_t;
    typedef struct packed {
        logic [MEM_ARB_ADDR_W-1:0]   addr;
        logic                        wen;
        logic [MEM_ARB_DATA_W-1:0]   wdata;
        logic [MEM_ARB_DATA_W/8-1:0] wmask;
    } mem_arb_req_t;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one-entry request capture buffer with pending flag
module mem_arb_slot
    import mem_arb_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  mem_arb_req_t data,
    input  logic         clear,
    output logic         pending,
    output mem_arb_req_t held
);
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= 1'b0;
            held    <= '0;
        end else if (valid && (!pending || clear)) begin
            pending <= 1'b1;
            held    <= data;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

    // A second pulse before the first is answered is dropped by the logic above
    assert property (@(posedge clock) disable iff (!reset) !(valid && pending && !clear))
        else $error("mem_arb_slot: request pulse while pending");
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IFU/LSU arbiter onto one single-outstanding memory port.
// Define MEM_ARB_TIMEOUT_EN to answer with an error after TIMEOUT_CYCLES silent WAIT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = MEM_ARB_ADDR_W,
    parameter int DATA_W         = MEM_ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_reqValid,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_respValid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_respErr,
    input  logic                lsu_reqValid,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_respValid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_respErr,
    output logic                mem_reqValid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_respValid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    mem_arb_state_t state;
    mem_arb_owner_t owner;
    mem_arb_req_t   ifu_req, lsu_req, ifu_held, lsu_held, grant_req;
    logic           ifu_pending, lsu_pending, grant_lsu, timeout, done;

    assign ifu_req = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
    assign lsu_req = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};

    mem_arb_slot u_ifu_slot (
        .clock   (clock),
        .reset   (reset),
        .valid   (ifu_reqValid),
        .data    (ifu_req),
        .clear   (ifu_respValid),
        .pending (ifu_pending),
        .held    (ifu_held)
    );

    mem_arb_slot u_lsu_slot (
        .clock   (clock),
        .reset   (reset),
        .valid   (lsu_reqValid),
        .data    (lsu_req),
        .clear   (lsu_respValid),
        .pending (lsu_pending),
        .held    (lsu_held)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    assign timeout = state == WAIT && !mem_respValid && wait_cnt == CNT_W'(TIMEOUT_CYCLES);
    always_ff @(posedge clock)
        wait_cnt <= (!reset || state != WAIT) ? '0 : wait_cnt + 1'b1;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // A real response wins over a timeout landing in the same cycle
    assign done          = state == WAIT && (mem_respValid || timeout);
    assign ifu_respValid = done && owner == OWN_IFU;
    assign lsu_respValid = done && owner == OWN_LSU;
    assign ifu_rdata     = ifu_respValid && !timeout ? mem_rdata : '0;
    assign lsu_rdata     = lsu_respValid && !timeout ? mem_rdata : '0;
    assign ifu_respErr   = ifu_respValid && timeout;
    assign lsu_respErr   = lsu_respValid && timeout;

    // owner doubles as last_grant: on a tie the requester not served last wins
    assign grant_lsu = lsu_pending && (!ifu_pending || owner == OWN_IFU);
    assign grant_req = grant_lsu ? lsu_held : ifu_held;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            owner        <= OWN_IFU;
            mem_reqValid <= 1'b0;
            mem_addr     <= '0;
            mem_wen      <= 1'b0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
        end else begin
            mem_reqValid <= 1'b0;
            case (state)
                IDLE: if (ifu_pending || lsu_pending) begin
                    owner        <= grant_lsu ? OWN_LSU : OWN_IFU;
                    mem_reqValid <= 1'b1;
                    mem_addr     <= grant_req.addr;
                    mem_wen      <= grant_req.wen;
                    mem_wdata    <= grant_req.wdata;
                    mem_wmask    <= grant_req.wmask;
                    state        <= REQ;
                end
                REQ:     state <= WAIT;
                WAIT:    if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ifu_reqValid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_respValid, ifu_respErr;
    logic [31:0] ifu_rdata;
    logic        lsu_reqValid = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_respValid, lsu_respErr;
    logic [31:0] lsu_rdata;
    logic        mem_reqValid, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
        .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata), .ifu_respErr(ifu_respErr),
        .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata), .lsu_respErr(lsu_respErr),
        .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic serve(input string tag, input bit lsu, input logic [31:0] addr,
                         input logic [31:0] rdata, input bit repulse, input logic [31:0] next_addr);
        int n = 0;
        while (!mem_reqValid && n < 6) begin
            cyc();
            n++;
        end
        check({tag, " req"}, 32'(mem_reqValid), 32'd1);
        check({tag, " addr"}, mem_addr, addr);
        cyc();
        mem_respValid = 1'b1;
        mem_rdata     = rdata;
        if (repulse && lsu) begin
            lsu_reqValid = 1'b1;
            lsu_addr     = next_addr;
        end else if (repulse) begin
            ifu_reqValid = 1'b1;
            ifu_addr     = next_addr;
        end
        #1;
        check({tag, " ifu_v"}, 32'(ifu_respValid), 32'(!lsu));
        check({tag, " lsu_v"}, 32'(lsu_respValid), 32'(lsu));
        check({tag, " ifu_d"}, ifu_rdata, lsu ? 32'd0 : rdata);
        check({tag, " lsu_d"}, lsu_rdata, lsu ? rdata : 32'd0);
        cyc();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        ifu_reqValid  = 1'b0;
        lsu_reqValid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          l;
        logic [31:0] base;
        cyc();
        cyc();
        check("rst mem_req", 32'(mem_reqValid), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst mem_wmask", 32'(mem_wmask), 32'd0);
        check("rst resp", 32'({ifu_respValid, lsu_respValid, ifu_respErr, lsu_respErr}), 32'd0);
        reset = 1'b1;

        // 1: single IFU fetch, exact latency
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0000;
        cyc();
        ifu_reqValid = 1'b0;
        check("t1 c1 req", 32'(mem_reqValid), 32'd0);
        cyc();
        check("t1 c2 req", 32'(mem_reqValid), 32'd1);
        check("t1 c2 addr", mem_addr, 32'h8000_0000);
        check("t1 c2 wen", 32'(mem_wen), 32'd0);
        cyc();
        check("t1 c3 req", 32'(mem_reqValid), 32'd0);
        mem_respValid = 1'b1;
        mem_rdata     = 32'h0000_0013;
        #1;
        check("t1 ifu_v", 32'(ifu_respValid), 32'd1);
        check("t1 ifu_d", ifu_rdata, 32'h13);
        check("t1 ifu_err", 32'(ifu_respErr), 32'd0);
        check("t1 lsu_v", 32'(lsu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        check("t1 after", 32'(ifu_respValid), 32'd0);

        // 2: simultaneous pulses after reset, LSU store wins the first tie
        reset = 1'b0;
        cyc();
        reset        = 1'b1;
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h100;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h1000;
        lsu_wen      = 1'b1;
        lsu_wdata    = 32'hDEAD_BEEF;
        lsu_wmask    = 4'hF;
        cyc();
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        cyc();
        check("t2 req", 32'(mem_reqValid), 32'd1);
        check("t2 addr", mem_addr, 32'h1000);
        check("t2 wen", 32'(mem_wen), 32'd1);
        check("t2 wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t2 wmask", 32'(mem_wmask), 32'hF);
        cyc();
        mem_respValid = 1'b1;
        #1;
        check("t2 lsu_v", 32'(lsu_respValid), 32'd1);
        check("t2 ifu_v0", 32'(ifu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b0;
        check("t2 gap", 32'(mem_reqValid), 32'd0);
        cyc();
        check("t2 ifu req", 32'(mem_reqValid), 32'd1);
        check("t2 ifu addr", mem_addr, 32'h100);
        check("t2 ifu wen", 32'(mem_wen), 32'd0);
        check("t2 ifu wmask", 32'(mem_wmask), 32'd0);
        check("t2 ifu wdata", mem_wdata, 32'd0);
        cyc();
        mem_respValid = 1'b1;
        mem_rdata     = 32'hAAAA_5555;
        #1;
        check("t2 ifu_v", 32'(ifu_respValid), 32'd1);
        check("t2 ifu_d", ifu_rdata, 32'hAAAA_5555);
        check("t2 lsu_v0", 32'(lsu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b0;
        mem_rdata     = '0;

        // 3: both keep requesting, grants alternate LSU, IFU, ...
        lsu_wen      = 1'b0;
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h4000;
        lsu_reqValid = 1'b1;
        lsu_addr     = 32'h2000;
        cyc();
        ifu_reqValid = 1'b0;
        lsu_reqValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            l    = k % 2 == 0;
            base = l ? 32'h2000 : 32'h4000;
            serve($sformatf("t3.%0d", k), l, base + 32'(4 * (k / 2)), 32'h1000_0000 + 32'(k),
                  k < 6, base + 32'(4 * (k / 2 + 1)));
        end

        // 4: stray response in IDLE is discarded, FSM still IDLE
        mem_respValid = 1'b1;
        mem_rdata     = 32'h55;
        #1;
        check("t4 ifu_v", 32'(ifu_respValid), 32'd0);
        check("t4 lsu_v", 32'(lsu_respValid), 32'd0);
        check("t4 rdata", ifu_rdata | lsu_rdata, 32'd0);
        cyc();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        check("t4 req", 32'(mem_reqValid), 32'd0);

        // 5: reset during WAIT, late response dropped
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0040;
        cyc();
        ifu_reqValid = 1'b0;
        check("t5 c1 req", 32'(mem_reqValid), 32'd0);
        cyc();
        check("t5 c2 req", 32'(mem_reqValid), 32'd1);
        check("t5 c2 addr", mem_addr, 32'h8000_0040);
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("t5 rst addr", mem_addr, 32'd0);
        check("t5 rst req", 32'(mem_reqValid), 32'd0);
        mem_respValid = 1'b1;
        mem_rdata     = 32'h77;
        #1;
        check("t5 late ifu_v", 32'(ifu_respValid), 32'd0);
        check("t5 late ifu_d", ifu_rdata, 32'd0);
        check("t5 late lsu_v", 32'(lsu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b0;
        mem_rdata     = '0;
        for (int i = 0; i < 3; i++) begin
            check("t5 no req", 32'(mem_reqValid), 32'd0);
            cyc();
        end

        // 6: silent memory
        ifu_reqValid = 1'b1;
        ifu_addr     = 32'h8000_0100;
        mem_rdata    = 32'h99;
        cyc();
        ifu_reqValid = 1'b0;
        cyc();
        check("t6 req", 32'(mem_reqValid), 32'd1);
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t6 wait v", 32'(ifu_respValid), 32'd0);
        end
        cyc();
        check("t6 tmo v", 32'(ifu_respValid), 32'd1);
        check("t6 tmo err", 32'(ifu_respErr), 32'd1);
        check("t6 tmo d", ifu_rdata, 32'd0);
        check("t6 tmo lsu", 32'(lsu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b1;
        #1;
        check("t6 late v", 32'(ifu_respValid), 32'd0);
        cyc();
        mem_respValid = 1'b0;
`else
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("t6 hold v", 32'(ifu_respValid), 32'd0);
            check("t6 hold err", 32'(ifu_respErr), 32'd0);
        end
        cyc();
        mem_respValid = 1'b1;
        #1;
        check("t6 resp v", 32'(ifu_respValid), 32'd1);
        check("t6 resp err", 32'(ifu_respErr), 32'd0);
        check("t6 resp d", ifu_rdata, 32'h99);
        cyc();
        mem_respValid = 1'b0;
`endif
        mem_rdata = '0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
